// File: rtl/ram_responder.sv
`default_nettype none
// ============================================================================
// Module   : ram_responder
// Brief    : RAM-side responder serving the core's read port with one-cycle
//            registered data and a posted byte-enable write FIFO drained into
//            a single-ported word array. Define RAM_RESPONDER_FWD_EN to let
//            reads byte-merge pending FIFO writes instead of stalling on them.
// Revision : 1.0 - initial release
// ============================================================================
module ram_responder #(
    parameter int DEPTH_WORDS  = 16384,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rd_ram_en,
    input  logic [15:0]                   rd_ram_addr,
    output logic [31:0]                   rd_ram_data,
    output logic                          rd_ram_valid,
    input  logic                          wr_ram_en,
    input  logic [31:0]                   wr_ram_addr,
    input  logic [31:0]                   wr_ram_data,
    input  logic [3:0]                    wr_ram_be,
    output logic                          wr_ram_ready,
    output logic [$clog2(FIFO_DEPTH):0]   wr_pending,
    output logic                          oob_err
);

    localparam int                  c_ptr_w      = $clog2(FIFO_DEPTH);
    localparam int                  c_addr_w     = $clog2(DEPTH_WORDS);
    localparam int                  c_starve_w   = $clog2(STARVE_LIMIT + 1);
    localparam logic [29:0]         c_depth      = 30'(DEPTH_WORDS);
    localparam logic [c_ptr_w:0]    c_full       = (c_ptr_w + 1)'(FIFO_DEPTH);
    localparam logic [c_starve_w-1:0] c_starve_max = c_starve_w'(STARVE_LIMIT);

    logic [31:0]           r_mem       [DEPTH_WORDS];
    logic [29:0]           r_fifo_addr [FIFO_DEPTH];
    logic [31:0]           r_fifo_data [FIFO_DEPTH];
    logic [3:0]            r_fifo_be   [FIFO_DEPTH];
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w:0]      r_count;
    logic [c_starve_w-1:0] r_starve;
    logic [31:0]           r_rd_data;
    logic                  r_rd_valid;
    logic                  r_oob;

    logic [29:0] w_rd_word;
    logic [29:0] w_wr_word;
    logic        w_rd_oob;
    logic        w_wr_oob;
    logic        w_rd_match;
    logic [31:0] w_rd_merged;
    logic [31:0] w_rd_result;
    logic        w_rd_stall;
    logic        w_fifo_empty;
    logic        w_forced;
    logic        w_do_read;
    logic        w_do_drain;
    logic        w_push;
    logic [29:0] w_pop_addr;
    logic [31:0] w_pop_data;
    logic [3:0]  w_pop_be;
    logic        w_pop_oob;
    logic        w_unused_bits;

    assign w_rd_word = {16'b0, rd_ram_addr[15:2]};
    assign w_wr_word = wr_ram_addr[31:2];
    assign w_rd_oob  = (w_rd_word >= c_depth);
    assign w_wr_oob  = (w_wr_word >= c_depth);

    // Walk the FIFO oldest to youngest so the youngest enabled byte wins.
    always_comb begin
        logic [c_ptr_w-1:0] idx;
        idx         = '0;
        w_rd_match  = 1'b0;
        w_rd_merged = r_mem[w_rd_word[c_addr_w-1:0]];
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            idx = r_rd_ptr + c_ptr_w'(i);
            if ((i < int'(r_count)) && (r_fifo_addr[idx] == w_rd_word)) begin
                w_rd_match = 1'b1;
`ifdef RAM_RESPONDER_FWD_EN
                for (int b = 0; b < 4; b++) begin
                    if (r_fifo_be[idx][b]) begin
                        w_rd_merged[8*b +: 8] = r_fifo_data[idx][8*b +: 8];
                    end
                end
`endif
            end
        end
    end

`ifdef RAM_RESPONDER_FWD_EN
    assign w_rd_stall = 1'b0;
`else
    assign w_rd_stall = w_rd_match;
`endif

    assign w_rd_result  = w_rd_oob ? 32'h0 : w_rd_merged;
    assign w_fifo_empty = (r_count == '0);
    assign w_forced     = (r_starve == c_starve_max) && !w_fifo_empty;
    assign w_do_read    = rd_ram_en && !w_forced && !w_rd_stall;
    assign w_do_drain   = !w_fifo_empty && !w_do_read;
    assign w_push       = wr_ram_en && wr_ram_ready;

    assign w_pop_addr = r_fifo_addr[r_rd_ptr];
    assign w_pop_data = r_fifo_data[r_rd_ptr];
    assign w_pop_be   = r_fifo_be[r_rd_ptr];
    assign w_pop_oob  = (w_pop_addr >= c_depth);

    assign w_unused_bits = &{1'b0, rd_ram_addr[1:0], wr_ram_addr[1:0], w_rd_match};

    always_ff @(posedge clk) begin
        if (w_do_drain && !w_pop_oob) begin
            for (int b = 0; b < 4; b++) begin
                if (w_pop_be[b]) begin
                    r_mem[w_pop_addr[c_addr_w-1:0]][8*b +: 8] <= w_pop_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= w_wr_word;
            r_fifo_data[r_wr_ptr] <= wr_ram_data;
            r_fifo_be[r_wr_ptr]   <= wr_ram_be;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_starve   <= '0;
            r_rd_data  <= 32'h0;
            r_rd_valid <= 1'b0;
            r_oob      <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_drain) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_do_drain})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_do_drain || w_fifo_empty) begin
                r_starve <= '0;
            end else if (w_do_read && (r_starve != c_starve_max)) begin
                r_starve <= r_starve + 1'b1;
            end
            r_rd_valid <= w_do_read;
            if (w_do_read) begin
                r_rd_data <= w_rd_result;
            end
            if ((w_do_read && w_rd_oob) || (w_push && w_wr_oob)) begin
                r_oob <= 1'b1;
            end
        end
    end

    assign rd_ram_data  = r_rd_data;
    assign rd_ram_valid = r_rd_valid;
    assign wr_ram_ready = (r_count != c_full);
    assign wr_pending   = r_count;
    assign oob_err      = r_oob;

endmodule
`default_nettype wire

// File: tb/tb_ram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_responder
// Brief    : Self-checking bench for ram_responder (default build, no
//            forwarding) with DEPTH_WORDS=1024: vector table plus sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_ram_en;
    logic [15:0] rd_ram_addr;
    logic [31:0] rd_ram_data;
    logic        rd_ram_valid;
    logic        wr_ram_en;
    logic [31:0] wr_ram_addr;
    logic [31:0] wr_ram_data;
    logic [3:0]  wr_ram_be;
    logic        wr_ram_ready;
    logic [2:0]  wr_pending;
    logic        oob_err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wbe;
        logic [15:0] raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    ram_responder #(
        .DEPTH_WORDS  (1024),
        .FIFO_DEPTH   (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rd_ram_en    (rd_ram_en),
        .rd_ram_addr  (rd_ram_addr),
        .rd_ram_data  (rd_ram_data),
        .rd_ram_valid (rd_ram_valid),
        .wr_ram_en    (wr_ram_en),
        .wr_ram_addr  (wr_ram_addr),
        .wr_ram_data  (wr_ram_data),
        .wr_ram_be    (wr_ram_be),
        .wr_ram_ready (wr_ram_ready),
        .wr_pending   (wr_pending),
        .oob_err      (oob_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_ram_en   = 1'b1;
        wr_ram_addr = a;
        wr_ram_data = d;
        wr_ram_be   = be;
        tick();
        wr_ram_en   = 1'b0;
    endtask

    task automatic wait_empty(input string nm);
        for (int k = 0; k < 16 && wr_pending != 0; k++) tick();
        chk({nm, "_drained"}, 32'(wr_pending), 32'd0);
    endtask

    task automatic do_read(input string nm, input logic [15:0] a, input logic [31:0] exp);
        rd_ram_en   = 1'b1;
        rd_ram_addr = a;
        tick();
        rd_ram_en   = 1'b0;
        chk({nm, "_valid"}, 32'(rd_ram_valid), 32'd1);
        chk({nm, "_data"}, rd_ram_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        int zeros;
        int zpos;
        int stalls;

        vecs[0]  = '{32'h14,  32'hDEADBEEF, 4'hF, 16'h0014, 32'hDEADBEEF};
        vecs[1]  = '{32'h20,  32'hCAFEF00D, 4'hF, 16'h0020, 32'hCAFEF00D};
        vecs[2]  = '{32'h14,  32'h00000055, 4'h1, 16'h0014, 32'hDEADBE55};
        vecs[3]  = '{32'h14,  32'h12000000, 4'h8, 16'h0014, 32'h12ADBE55};
        vecs[4]  = '{32'h14,  32'hFFFFFFFF, 4'h0, 16'h0014, 32'h12ADBE55};
        vecs[5]  = '{32'h24,  32'h01020304, 4'hF, 16'h0024, 32'h01020304};
        vecs[6]  = '{32'h24,  32'hAABBCCDD, 4'h6, 16'h0024, 32'h01BBCC04};
        vecs[7]  = '{32'hFFC, 32'h5A5A5A5A, 4'hF, 16'h0FFC, 32'h5A5A5A5A};
        vecs[8]  = '{32'h38,  32'h0E0E0E0E, 4'hF, 16'h0038, 32'h0E0E0E0E};
        vecs[9]  = '{32'h50,  32'h20202020, 4'hF, 16'h0050, 32'h20202020};
        vecs[10] = '{32'h16,  32'h00770000, 4'h4, 16'h0017, 32'h1277BE55};
        vecs[11] = '{32'h0,   32'h0000C0DE, 4'hF, 16'h0000, 32'h0000C0DE};

        reset       = 1'b1;
        rd_ram_en   = 1'b0;
        rd_ram_addr = '0;
        wr_ram_en   = 1'b0;
        wr_ram_addr = '0;
        wr_ram_data = '0;
        wr_ram_be   = '0;
        tick();
        tick();
        chk("rst_rd_data", rd_ram_data, 32'h0);
        chk("rst_rd_valid", 32'(rd_ram_valid), 32'd0);
        chk("rst_ready", 32'(wr_ram_ready), 32'd1);
        chk("rst_pending", 32'(wr_pending), 32'd0);
        chk("rst_oob", 32'(oob_err), 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) begin
            push(vecs[i].waddr, vecs[i].wdata, vecs[i].wbe);
            wait_empty($sformatf("vec%0d", i));
            do_read($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp);
        end
        chk("oob_clear_in_range", 32'(oob_err), 32'd0);

        // Starvation: one pending write behind a continuous read stream.
        rd_ram_en   = 1'b1;
        rd_ram_addr = 16'h0014;
        tick();
        tick();
        push(32'h20, 32'h11223344, 4'b0011);
        zeros = 0;
        zpos  = -1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (!rd_ram_valid) begin
                zeros++;
                if (zpos < 0) zpos = k;
            end
        end
        rd_ram_en = 1'b0;
        chk("starve_invalid_cycles", 32'(zeros), 32'd1);
        chk("starve_drain_slot", 32'(zpos), 32'd9);
        chk("starve_pending", 32'(wr_pending), 32'd0);
        do_read("starve_word8", 16'h0020, 32'hCAFE3344);

        // Read hitting two pending writes stalls until both drain.
        rd_ram_en   = 1'b1;
        rd_ram_addr = 16'h0014;
        push(32'h0C, 32'hAAAAAAAA, 4'hF);
        push(32'h0C, 32'h000000BB, 4'h1);
        rd_ram_addr = 16'h000C;
        stalls = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (rd_ram_valid) break;
            stalls++;
        end
        rd_ram_en = 1'b0;
        chk("coh_stalls", 32'(stalls), 32'd2);
        chk("coh_valid", 32'(rd_ram_valid), 32'd1);
        chk("coh_data", rd_ram_data, 32'hAAAAAABB);

        // Fill the FIFO while reads hold the array.
        rd_ram_en   = 1'b1;
        rd_ram_addr = 16'h0014;
        for (int k = 0; k < 4; k++) begin
            push(32'h28 + 32'(4 * k), {4{8'hA0 + 8'(k)}}, 4'hF);
        end
        chk("full_pending", 32'(wr_pending), 32'd4);
        chk("full_ready", 32'(wr_ram_ready), 32'd0);
        rd_ram_en = 1'b0;
        push(32'h38, 32'hFFFFFFFF, 4'hF);
        chk("full_pop_no_room", 32'(wr_pending), 32'd3);
        chk("full_ready_back", 32'(wr_ram_ready), 32'd1);
        wait_empty("full");
        do_read("full_last", 16'h0034, 32'hA3A3A3A3);
        do_read("full_dropped", 16'h0038, 32'h0E0E0E0E);

        // Out-of-range read and write.
        do_read("oob_rd", 16'hFFFC, 32'h0);
        chk("oob_set", 32'(oob_err), 32'd1);
        tick();
        tick();
        chk("oob_sticky", 32'(oob_err), 32'd1);
        push(32'h1000, 32'h99999999, 4'hF);
        wait_empty("oob_wr");
        do_read("oob_wr_alias", 16'h0000, 32'h0000C0DE);

        // Reset with writes pending, asserted mid-read.
        rd_ram_en   = 1'b1;
        rd_ram_addr = 16'h0014;
        for (int k = 0; k < 3; k++) push(32'h50, 32'hBAD00000 + 32'(k), 4'hF);
        chk("pre_rst_pending", 32'(wr_pending), 32'd3);
        #2;
        reset     = 1'b1;
        rd_ram_en = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rd_ram_valid), 32'd0);
        chk("mid_rst_pending", 32'(wr_pending), 32'd0);
        chk("mid_rst_ready", 32'(wr_ram_ready), 32'd1);
        chk("mid_rst_oob", 32'(oob_err), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        do_read("rst_lost_writes", 16'h0050, 32'h20202020);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_responder.md
# ram_responder

Memory-side responder for the execution core's RAM ports. Serves the instruction-fetch read port with one-cycle registered read data. Accepts data writes into a posted write FIFO that drains into a single-ported word array. Sits between the core's `rd_ram_*`/`wr_ram_*` ports and on-chip storage; reads hitting pending writes are kept coherent.

## Interface
Parameters:
- `DEPTH_WORDS`, 16384: array depth in 32-bit words (64 KiB).
- `FIFO_DEPTH`, 4: posted-write entries, power of two, ≥2.
- `STARVE_LIMIT`, 8: consecutive read-serviced cycles with pending writes before a forced drain.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `rd_ram_en` in 1: read request.
- `rd_ram_addr` in 16: byte address; `[1:0]` ignored.
- `rd_ram_data` out 32: read data.
- `rd_ram_valid` out 1: request of previous cycle was serviced.
- `wr_ram_en` in 1: write request.
- `wr_ram_addr` in 32: byte address; `[1:0]` ignored.
- `wr_ram_data` in 32: write data.
- `wr_ram_be` in 4: byte enables; bit i selects byte i (bits `[8i+7:8i]`).
- `wr_ram_ready` out 1: FIFO can accept a write.
- `wr_pending` out `$clog2(FIFO_DEPTH)+1`: occupied FIFO entries.
- `oob_err` out 1: sticky out-of-range access flag.

## Operation
- The array has one access per cycle.
- Arbitration each cycle, in priority order:
  - forced drain, if `starve_cnt == STARVE_LIMIT` and FIFO non-empty;
  - read, if `rd_ram_en`;
  - drain, if FIFO non-empty;
  - idle.
- **Drain:** pops the oldest entry and writes only the enabled bytes. An entry with `be == 0` is popped with no array change.
- **Starvation counter:**
  - increments on a cycle where a read is serviced and the FIFO is non-empty;
  - clears on any drain or when the FIFO is empty;
  - saturates at `STARVE_LIMIT`.
- **Write acceptance:** a write is accepted when `wr_ram_en && wr_ram_ready` at a rising edge.
  - `wr_ram_ready = (wr_pending != FIFO_DEPTH)`, derived from the registered count only.
  - When the FIFO is full, a same-cycle pop does not make room.
  - Push and pop in the same cycle leave the count unchanged.
- **Coherence:** a serviced read sees the array plus all FIFO entries present at the start of that cycle. Matching is by word address.
  - Bytes are merged oldest to youngest, so the youngest enabled byte wins.
  - A write pushed on the same edge as the read is not visible to it.
- **Out-of-range addresses** (word address ≥ `DEPTH_WORDS`):
  - a read returns `32'h0` with `rd_ram_valid=1`;
  - a write is accepted and then discarded at drain;
  - both set `oob_err`, which is cleared only by reset.
- **Reset:** clears the FIFO (pending writes are lost) and the starvation counter. Array contents are not reset.

## Timing
- Read latency is one cycle: request at edge N gives `rd_ram_data`/`rd_ram_valid` valid after edge N+1.
- If the read is not serviced (forced drain, or a stall under the configuration below):
  - `rd_ram_valid=0` in the next cycle;
  - `rd_ram_data` holds its last value;
  - the requester re-presents the request.
- `rd_ram_valid=0` in the cycle after a cycle with `rd_ram_en=0`.
- A write accepted at edge N is drainable from cycle N+1; the earliest array update is at edge N+1.
- Reset values:
  - `rd_ram_data=0`
  - `rd_ram_valid=0`
  - `wr_ram_ready=1`
  - `wr_pending=0`
  - `oob_err=0`
- Asserting `reset` mid-read forces `rd_ram_valid=0` immediately.

## Configuration
- `RAM_RESPONDER_FWD_EN` defined: byte-merging forwarding from the FIFO, as described in Operation.
- Undefined: a read whose word address matches any FIFO entry is not serviced. The slot goes to drain instead, and `rd_ram_valid=0` next cycle. The read is serviced once no entry matches. Non-matching reads behave identically in both builds.

## Test plan
- Reset, preload word 5 = `32'hDEADBEEF` through the write port, idle the read port until `wr_pending==0`. Then read addr `16'h0014` → `rd_ram_data=32'hDEADBEEF`, `rd_ram_valid=1` one cycle later.
- Hold `rd_ram_en=1`, write addr `0x20` data `32'h11223344` be `4'b0011`. Expect:
  - forced drain after 8 serviced reads, with exactly one cycle of `rd_ram_valid=0`;
  - word 8 low half = `16'h3344`, high half unchanged.
- With `FWD_EN`, push writes to word 3: `32'hAAAAAAAA` be `4'hF`, then `32'h000000BB` be `4'h1`. Read word 3 before the drain → `32'hAAAAAABB`. Without `FWD_EN` → `rd_ram_valid=0` until both entries drain, then `32'hAAAAAABB`.
- Push 4 writes with `rd_ram_en=1` → `wr_ram_ready=0`, `wr_pending=4`. A 5th `wr_ram_en` is ignored. Ready rises the cycle after the first drain.
- Read addr `16'hFFFC` with `DEPTH_WORDS=1024` → data `0`, `oob_err=1`. The flag stays set until `reset`.
- Assert `reset` with 3 writes pending → `wr_pending=0`, `wr_ram_ready=1`. The pending writes never reach the array.
